// File: rtl/ebr_fifo_ctrl_if.sv
// Bundle for ebr_fifo_ctrl: producer/consumer handshakes, EBR port, and occupancy flags.
// slave is the controller's view; master is the environment (producer, consumer, EBR).
interface ebr_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              ebr_we;
  logic [ADDR_W-1:0] ebr_wa;
  logic [DATA_W-1:0] ebr_wd;
  logic              ebr_re;
  logic [ADDR_W-1:0] ebr_ra;
  logic [DATA_W-1:0] ebr_rd;
  logic [ADDR_W+1:0] count;
  logic              almost_full;
  logic              almost_empty;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ebr_rd,
    output wr_ready, rd_valid, rd_data, ebr_we, ebr_wa, ebr_wd,
           ebr_re, ebr_ra, count, almost_full, almost_empty
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ebr_rd,
    input  wr_ready, rd_valid, rd_data, ebr_we, ebr_wa, ebr_wd,
           ebr_re, ebr_ra, count, almost_full, almost_empty
  );
endinterface

// File: rtl/ebr_fifo_ctrl.sv
// FIFO controller around a 1-cycle-latency EBR, with a 2-entry output skid buffer
// so the consumer sees a full-throughput valid/ready stream.
module ebr_fifo_ctrl #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned AFULL_THR  = 1020,
  parameter int unsigned AEMPTY_THR = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  ebr_fifo_ctrl_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned MCNT_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 2;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [MCNT_W-1:0] mem_cnt;
  logic              inflight;
  logic              run;
  logic [1:0]        occ;
  logic [DATA_W-1:0] sk0;
  logic [DATA_W-1:0] sk1;

  logic              wr_ready_c;
  logic              push_c;
  logic              pop_c;
  logic              re_c;
  logic [2:0]        after_pop_c;
  logic [CNT_W-1:0]  count_c;

  // Handshakes and read-issue decision; a read is issued only if the skid can absorb it.
  always_comb begin
    wr_ready_c  = run && (mem_cnt < MCNT_W'(DEPTH)) && !flush;
    push_c      = bus.wr_valid && wr_ready_c;
    pop_c       = (occ != 2'd0) && bus.rd_ready && !flush;
    after_pop_c = 3'(occ) + 3'(inflight) - 3'(pop_c);
    re_c        = (mem_cnt != MCNT_W'(0)) && !flush && (after_pop_c < 3'd2);
    count_c     = CNT_W'(mem_cnt) + CNT_W'(inflight) + CNT_W'(occ);
  end

  assign bus.wr_ready     = wr_ready_c;
  assign bus.ebr_we       = push_c;
  assign bus.ebr_wa       = wptr;
  assign bus.ebr_wd       = bus.wr_data;
  assign bus.ebr_re       = re_c;
  assign bus.ebr_ra       = rptr;
  assign bus.rd_valid     = (occ != 2'd0);
  assign bus.rd_data      = sk0;
  assign bus.count        = count_c;
  assign bus.almost_full  = (count_c >= CNT_W'(AFULL_THR));
  assign bus.almost_empty = (count_c <= CNT_W'(AEMPTY_THR));

  // Pointers, EBR occupancy and read pipeline; run holds wr_ready low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        wptr     <= '0;
        rptr     <= '0;
        mem_cnt  <= '0;
        inflight <= 1'b0;
      end else begin
        if (push_c) wptr <= wptr + ADDR_W'(1);
        if (re_c)   rptr <= rptr + ADDR_W'(1);
        mem_cnt  <= mem_cnt + MCNT_W'(push_c) - MCNT_W'(re_c);
        inflight <= re_c;
      end
    end
  end

  // Skid buffer: sk0 is the head; returning EBR data lands behind any held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 2'd0;
      sk0 <= '0;
      sk1 <= '0;
    end else if (flush) begin
      occ <= 2'd0;
      sk0 <= '0;
      sk1 <= '0;
    end else begin
      unique case ({pop_c, inflight})
        2'b01: begin
          if (occ == 2'd0) sk0 <= bus.ebr_rd;
          else             sk1 <= bus.ebr_rd;
          occ <= occ + 2'd1;
        end
        2'b10: begin
          sk0 <= sk1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            sk0 <= bus.ebr_rd;
          end else begin
            sk0 <= sk1;
            sk1 <= bus.ebr_rd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ebr_fifo_ctrl.sv
// Self-checking bench for ebr_fifo_ctrl: an EBR memory model, a queue-based reference
// model checked every cycle on the falling edge, and directed scenarios with literal checks.
module tb_ebr_fifo_ctrl;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned AFULL  = 1020;
  localparam int unsigned AEMPTY = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  ebr_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ebr_fifo_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_THR(AFULL), .AEMPTY_THR(AEMPTY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // EBR model: synchronous write, read data valid one cycle after ebr_re.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ebr_we) ram[bus.ebr_wa] <= bus.ebr_wd;
    if (bus.ebr_re) bus.ebr_rd <= ram[bus.ebr_ra];
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: item counts in memory / in flight / in skid, pointers, and an
  // ordered queue of every word accepted and not yet delivered.
  int                m, f, s, wp, rp;
  bit                run;
  logic [DATA_W-1:0] q[$];
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  bit                p_wr_ready, p_push, p_pop, p_re;
  int                p_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wr_ready",     64'(bus.wr_ready),     64'(0));
      chk("rst_rd_valid",     64'(bus.rd_valid),     64'(0));
      chk("rst_ebr_we",       64'(bus.ebr_we),       64'(0));
      chk("rst_ebr_re",       64'(bus.ebr_re),       64'(0));
      chk("rst_count",        64'(bus.count),        64'(0));
      chk("rst_almost_full",  64'(bus.almost_full),  64'(0));
      chk("rst_almost_empty", 64'(bus.almost_empty), 64'(1));
      chk("rst_rd_data",      64'(bus.rd_data),      64'(0));
      m = 0; f = 0; s = 0; wp = 0; rp = 0; run = 1'b0;
      q.delete();
      prev_stall = 1'b0;
    end else begin
      p_wr_ready = run && (m < DEPTH) && !flush;
      p_push     = bus.wr_valid && p_wr_ready;
      p_pop      = (s > 0) && bus.rd_ready && !flush;
      p_re       = (m > 0) && !flush && ((s + f - int'(p_pop)) < 2);
      p_cnt      = m + f + s;

      chk("wr_ready",     64'(bus.wr_ready),     64'(p_wr_ready));
      chk("rd_valid",     64'(bus.rd_valid),     64'(s > 0));
      chk("count",        64'(bus.count),        64'(p_cnt));
      chk("almost_full",  64'(bus.almost_full),  64'(p_cnt >= AFULL));
      chk("almost_empty", 64'(bus.almost_empty), 64'(p_cnt <= AEMPTY));
      chk("ebr_we",       64'(bus.ebr_we),       64'(p_push));
      chk("ebr_re",       64'(bus.ebr_re),       64'(p_re));
      if (p_push) begin
        chk("ebr_wa", 64'(bus.ebr_wa), 64'(wp));
        chk("ebr_wd", 64'(bus.ebr_wd), 64'(bus.wr_data));
      end
      if (p_re) chk("ebr_ra", 64'(bus.ebr_ra), 64'(rp));
      if (p_push && p_re) chk("ra_ne_wa", 64'(bus.ebr_ra != bus.ebr_wa), 64'(1));
      if (s > 0) chk("rd_data_order", 64'(bus.rd_data), 64'(q[0]));
      if (prev_stall) chk("rd_data_stable", 64'(bus.rd_data), 64'(prev_data));
      prev_stall = (s > 0) && !bus.rd_ready && !flush;
      prev_data  = bus.rd_data;

      run = 1'b1;
      if (flush) begin
        m = 0; f = 0; s = 0; wp = 0; rp = 0;
        q.delete();
      end else begin
        if (p_pop)  void'(q.pop_front());
        if (p_push) q.push_back(bus.wr_data);
        s  = s - int'(p_pop) + f;
        f  = int'(p_re);
        m  = m + int'(p_push) - int'(p_re);
        wp = (wp + int'(p_push)) % DEPTH;
        rp = (rp + int'(p_re)) % DEPTH;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // One word through an empty FIFO: ebr_re in cycle 1, rd_valid in cycle 3.
  task automatic single_wr_rd(input logic [DATA_W-1:0] d, input string tag);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    settle();
    chk({tag, "_c0_we"},    64'(bus.ebr_we),   64'(1));
    chk({tag, "_c0_count"}, 64'(bus.count),    64'(0));
    tick();
    bus.wr_valid = 1'b0;
    settle();
    chk({tag, "_c1_re"},    64'(bus.ebr_re),   64'(1));
    chk({tag, "_c1_count"}, 64'(bus.count),    64'(1));
    chk({tag, "_c1_valid"}, 64'(bus.rd_valid), 64'(0));
    tick();
    settle();
    chk({tag, "_c2_count"}, 64'(bus.count),    64'(1));
    chk({tag, "_c2_valid"}, 64'(bus.rd_valid), 64'(0));
    tick();
    settle();
    chk({tag, "_c3_valid"}, 64'(bus.rd_valid), 64'(1));
    chk({tag, "_c3_data"},  64'(bus.rd_data),  64'(d));
    tick();
    bus.rd_ready = 1'b1;
    settle();
    tick();
    bus.rd_ready = 1'b0;
    settle();
    chk({tag, "_end_count"}, 64'(bus.count),    64'(0));
    chk({tag, "_end_valid"}, 64'(bus.rd_valid), 64'(0));
    tick();
  endtask

  int acc, pops, bubbles, first_pop, last_pop;

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    settle();
    tick();
    settle();
    chk("wr_ready_after_reset", 64'(bus.wr_ready), 64'(1));
    tick();

    single_wr_rd(18'h00155, "first");

    // Fill with consumer stalled: 1024 in EBR plus 2 in the skid.
    acc = 0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 1040; i++) begin
      bus.wr_data = DATA_W'(32'h100 + acc);
      settle();
      if (bus.wr_ready) acc++;
      tick();
    end
    bus.wr_valid = 1'b0;
    settle();
    chk("fill_accepted",    64'(acc),              64'(1026));
    chk("fill_count",       64'(bus.count),        64'(1026));
    chk("fill_wr_ready",    64'(bus.wr_ready),     64'(0));
    chk("fill_almost_full", 64'(bus.almost_full),  64'(1));
    tick();

    // Drain with consumer always ready.
    pops = 0; bubbles = 0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      settle();
      if (bus.rd_valid) pops++;
      else if (pops > 0 && pops < 1026) bubbles++;
      tick();
    end
    bus.rd_ready = 1'b0;
    settle();
    chk("drain_pops",    64'(pops),         64'(1026));
    chk("drain_bubbles", 64'(bubbles),      64'(0));
    chk("drain_count",   64'(bus.count),    64'(0));
    chk("drain_valid",   64'(bus.rd_valid), 64'(0));
    tick();

    // Streaming 3000 words; pointers wrap several times.
    acc = 0; pops = 0; first_pop = -1; last_pop = -1;
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 3200 && pops < 3000; c++) begin
      bus.wr_valid = (acc < 3000);
      bus.wr_data  = DATA_W'(acc * 5 + 7);
      settle();
      if (bus.wr_valid && bus.wr_ready) acc++;
      if (bus.rd_valid) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    chk("stream_pops",      64'(pops),               64'(3000));
    chk("stream_first_pop", 64'(first_pop),          64'(3));
    chk("stream_span",      64'(last_pop - first_pop), 64'(2999));

    // Consumer toggling every cycle.
    acc = 0; pops = 0;
    for (int c = 0; c < 600; c++) begin
      bus.wr_valid = (acc < 200);
      bus.rd_ready = (c % 2) == 1;
      bus.wr_data  = DATA_W'(acc + 20000);
      settle();
      if (bus.wr_valid && bus.wr_ready) acc++;
      if (bus.rd_valid && bus.rd_ready) pops++;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    settle();
    chk("toggle_written", 64'(acc),       64'(200));
    chk("toggle_read",    64'(pops),      64'(200));
    chk("toggle_count",   64'(bus.count), 64'(0));
    tick();

    // Flush in the cycle a read would be issued.
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h0002A;
    settle();
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 18'h0002B;
    flush = 1'b1;
    settle();
    chk("flush_re_suppressed", 64'(bus.ebr_re),   64'(0));
    chk("flush_we_suppressed", 64'(bus.ebr_we),   64'(0));
    chk("flush_wr_ready",      64'(bus.wr_ready), 64'(0));
    tick();
    flush = 1'b0;
    bus.wr_valid = 1'b0;
    settle();
    chk("post_flush_count",   64'(bus.count),        64'(0));
    chk("post_flush_valid",   64'(bus.rd_valid),     64'(0));
    chk("post_flush_data",    64'(bus.rd_data),      64'(0));
    chk("post_flush_aempty",  64'(bus.almost_empty), 64'(1));
    chk("post_flush_wrready", 64'(bus.wr_ready),     64'(1));
    tick();
    single_wr_rd(18'h000AB, "after_flush");

    // Flush while read data is returning and the skid holds entries.
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = DATA_W'(32'h3000 + i);
      settle();
      tick();
    end
    bus.wr_valid = 1'b0;
    settle();
    tick();
    flush = 1'b1;
    bus.rd_ready = 1'b1;
    settle();
    tick();
    flush = 1'b0;
    bus.rd_ready = 1'b0;
    settle();
    chk("flush2_count", 64'(bus.count),    64'(0));
    chk("flush2_valid", 64'(bus.rd_valid), 64'(0));
    chk("flush2_data",  64'(bus.rd_data),  64'(0));
    tick();
    settle();
    chk("flush2_no_stale", 64'(bus.rd_valid), 64'(0));
    tick();
    single_wr_rd(18'h1C0DE, "after_flush2");

    // Reset pulse mid-stream, with reads in flight.
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_data = DATA_W'(32'h5000 + i);
      settle();
      tick();
    end
    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    chk("async_rst_wr_ready", 64'(bus.wr_ready),     64'(0));
    chk("async_rst_valid",    64'(bus.rd_valid),     64'(0));
    chk("async_rst_count",    64'(bus.count),        64'(0));
    chk("async_rst_data",     64'(bus.rd_data),      64'(0));
    chk("async_rst_aempty",   64'(bus.almost_empty), 64'(1));
    settle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    settle();
    chk("post_rst_wr_ready", 64'(bus.wr_ready), 64'(1));
    chk("post_rst_count",    64'(bus.count),    64'(0));
    tick();
    single_wr_rd(18'h2F0F0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/ebr_fifo_ctrl.md
EBR_FIFO_CTRL -- requirements
Module: ebr_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18: data width; must match the EBR port width.
REQ-002 The block SHALL have parameter ADDR_W, default 10: EBR address width. DEPTH = 2^ADDR_W.
REQ-003 The block SHALL have parameter AFULL_THR, default 1020: almost_full asserts at count >= AFULL_THR.
REQ-004 The block SHALL have parameter AEMPTY_THR, default 4: almost_empty asserts at count <= AEMPTY_THR.
REQ-005 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock for all logic and both EBR ports.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_data  in  DATA_W  write payload.
- rd_valid  out  1  output data valid.
- rd_ready  in  1  consumer accept.
- rd_data  out  DATA_W  output payload.
- ebr_we  out  1  EBR write enable.
- ebr_wa  out  ADDR_W  EBR write address.
- ebr_wd  out  DATA_W  EBR write data.
- ebr_re  out  1  EBR read enable.
- ebr_ra  out  ADDR_W  EBR read address.
- ebr_rd  in  DATA_W  EBR read data, valid exactly 1 cycle after ebr_re.
- count  out  ADDR_W+2  total entries held.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.

Function
REQ-006 The block SHALL complete a write handshake when wr_valid && wr_ready.
REQ-007 The block SHALL complete a read handshake when rd_valid && rd_ready.
REQ-008 The block SHALL keep the following state:
- wptr and rptr, ADDR_W bits each, wrapping modulo DEPTH.
- mem_cnt, 0..DEPTH: entries in EBR not yet read.
- inflight, 1 bit: an EBR read whose data returns this cycle.
- 2-entry output skid buffer, occ 0..2.
REQ-009 wr_ready SHALL equal (mem_cnt < DEPTH) && !flush.
REQ-010 On a write handshake, in the same cycle, the block SHALL drive ebr_we=1, ebr_wa=wptr and ebr_wd=wr_data; wptr SHALL increment at the next edge.
REQ-011 ebr_re SHALL be 1 when mem_cnt > 0 && !flush && (occ + inflight - pop) < 2, where pop is the read handshake; ebr_ra=rptr, and rptr SHALL increment at the next edge.
REQ-012 When inflight=1, ebr_rd SHALL be written into the skid buffer at the end of that cycle, in FIFO order behind existing entries.
REQ-013 rd_valid SHALL equal occ > 0; rd_data SHALL be the oldest skid entry and SHALL be held stable while rd_valid && !rd_ready.
REQ-014 mem_cnt SHALL update by +write -ebr_re each cycle; a simultaneous write and read SHALL leave it unchanged.
REQ-015 count SHALL equal mem_cnt + inflight + occ; maximum DEPTH+2.
REQ-016 Latency: a write accepted in cycle 0 into an empty FIFO SHALL produce rd_valid=1 in cycle 3.
REQ-017 Throughput: with wr_valid and rd_ready continuously high, after fill the block SHALL sustain 1 transfer per cycle with no bubbles.
REQ-018 A read SHALL never address an unwritten location: ebr_re requires mem_cnt > 0, so ebr_ra != ebr_wa whenever both enables are 1.
REQ-019 Wrap-around: pointers SHALL roll from DEPTH-1 to 0 without loss, with ordering preserved.
REQ-020 The block SHALL assert almost_full and almost_empty combinationally from count.
REQ-021 flush=1 SHALL suppress all handshakes and EBR enables in that cycle.
REQ-022 flush=1 SHALL, at the next edge, set wptr, rptr, mem_cnt, inflight and occ to 0.
REQ-023 Read data returning in a flush cycle SHALL be discarded.

Reset
REQ-024 The block SHALL respond to rst_n=0 immediately, independent of clk, by clearing all state: wptr=rptr=0, mem_cnt=0, inflight=0, occ=0.
REQ-025 While rst_n=0, outputs SHALL be: wr_ready=0, rd_valid=0, ebr_we=0, ebr_re=0, count=0, almost_full=0, almost_empty=1, rd_data=0.
REQ-026 wr_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-027 Reset during an in-flight read SHALL discard the returning data.

Verification
REQ-028 Single write of 0x155 into an empty FIFO at cycle 0 -> ebr_re in cycle 1; rd_valid=1 with rd_data=0x155 in cycle 3; count=1 from cycle 1.
REQ-029 Write 1026 words with rd_ready=0 -> wr_ready=0 after word 1026; count=1026; almost_full=1 from count 1020.
REQ-030 Drain the full FIFO with rd_ready=1 -> data in order; no bubbles; rd_valid falls after the last word.
REQ-031 Continuous streaming of 3000 words (wraps pointers) -> data in order; steady state 1 word/cycle.
REQ-032 rd_ready toggling every cycle during streaming -> no loss, no duplication; rd_data stable while stalled.
REQ-033 Two cases -> all outputs return to reset values, then a subsequent write/read works:
- flush asserted in the cycle ebr_re=1.
- rst_n pulsed low mid-stream.
